// File: rtl/string_pkg.sv
// Shared character definitions, line-length default and classifier types.
package string_pkg;

  localparam int unsigned CHAR_W       = 8;
  localparam int unsigned MAX_LINE_LEN = 16;

  typedef logic [CHAR_W-1:0] char_t;

  localparam char_t CHAR_NEWLINE = 8'h0A;
  localparam char_t CHAR_EOF     = 8'h00;
  localparam char_t CHAR_A       = 8'h61;
  localparam char_t CHAR_Z       = 8'h7A;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } cls_state_e;

  typedef struct packed {
    logic repeat_found;
    logic pair_found;
    logic overflow;
  } line_flags_t;

endpackage

// File: rtl/pair_history.sv
// Letter history of the current line plus parallel repeat (i vs i-2) and
// non-overlapping pair compares for the letter being written at index len.
module pair_history
  import string_pkg::*;
#(
  parameter int unsigned DEPTH = MAX_LINE_LEN
) (
  input  logic                         clk,
  input  logic                         wr_en,
  input  logic [$clog2(DEPTH+1)-1:0]   len,
  input  char_t                        wr_char,
  output logic                         repeat_hit_c,
  output logic                         pair_hit_c
);

  localparam int unsigned LEN_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  char_t hist_q [DEPTH];
  char_t prev1;
  char_t prev2;

  // Contents are qualified by len only, so no reset is needed.
  always_ff @(posedge clk) begin
    if (wr_en && (len < LEN_W'(DEPTH))) begin
      hist_q[IDX_W'(len)] <= wr_char;
    end
  end

  // Stored pairs (j, j+1) must end at or before i-2 to avoid overlap.
  always_comb begin
    prev1        = hist_q[IDX_W'(len - LEN_W'(1))];
    prev2        = hist_q[IDX_W'(len - LEN_W'(2))];
    repeat_hit_c = (len >= LEN_W'(2)) && (prev2 == wr_char);
    pair_hit_c   = 1'b0;
    for (int j = 0; j + 1 < int'(DEPTH); j++) begin
      if ((int'(len) >= j + 3) && (hist_q[j] == prev1) && (hist_q[j+1] == wr_char)) begin
        pair_hit_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nice_string_classifier.sv
// Streams ASCII bytes, classifies each newline/EOF-terminated line as nice
// (a letter repeat at distance 2 and a non-overlapping repeated pair).
module nice_string_classifier #(
  parameter int unsigned INBOUND_DATA_WIDTH = 8,
  parameter int unsigned MAX_LINE_LEN       = string_pkg::MAX_LINE_LEN
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          inbound_valid,
  input  logic [INBOUND_DATA_WIDTH-1:0] inbound_data,
  output logic                          string_is_nice,
  output logic                          end_of_file
);

  import string_pkg::*;

  localparam int unsigned LEN_W = $clog2(MAX_LINE_LEN + 1);
  localparam int unsigned DW    = INBOUND_DATA_WIDTH;

  cls_state_e        state_q;
  cls_state_e        state_d;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  len_d;
  line_flags_t       flags_q;
  line_flags_t       flags_d;
  logic              nice_d;
  logic              eof_d;

  logic              accept_c;
  logic              is_letter_c;
  logic              is_newline_c;
  logic              is_eof_c;
  logic              line_full_c;
  logic              wr_en_c;
  logic              repeat_hit_c;
  logic              pair_hit_c;
  char_t             wr_char_c;

  // Byte decode; anything that is not a letter, newline or EOF is dropped.
  assign accept_c     = inbound_valid && (state_q == ST_RUN);
  assign is_letter_c  = accept_c && (inbound_data >= DW'(CHAR_A)) && (inbound_data <= DW'(CHAR_Z));
  assign is_newline_c = accept_c && (inbound_data == DW'(CHAR_NEWLINE));
  assign is_eof_c     = accept_c && (inbound_data == DW'(CHAR_EOF));
  assign line_full_c  = (len_q == LEN_W'(MAX_LINE_LEN));
  assign wr_en_c      = is_letter_c && !line_full_c;
  assign wr_char_c    = CHAR_W'(inbound_data);

  pair_history #(
    .DEPTH (MAX_LINE_LEN)
  ) u_pair_history (
    .clk          (clk),
    .wr_en        (wr_en_c),
    .len          (len_q),
    .wr_char      (wr_char_c),
    .repeat_hit_c (repeat_hit_c),
    .pair_hit_c   (pair_hit_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_RUN;
      len_q          <= '0;
      flags_q        <= '0;
      string_is_nice <= 1'b0;
      end_of_file    <= 1'b0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      flags_q        <= flags_d;
      string_is_nice <= nice_d;
      end_of_file    <= eof_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (is_eof_c) begin
      state_d = ST_DONE;
    end
  end

  // Line bookkeeping and classification of the terminated line.
  always_comb begin
    len_d   = len_q;
    flags_d = flags_q;
    nice_d  = 1'b0;
    eof_d   = end_of_file || is_eof_c;
    if (wr_en_c) begin
      len_d                = len_q + LEN_W'(1);
      flags_d.repeat_found = flags_q.repeat_found || repeat_hit_c;
      flags_d.pair_found   = flags_q.pair_found || pair_hit_c;
    end else if (is_letter_c) begin
      flags_d.overflow = 1'b1;
    end
    if (is_newline_c || is_eof_c) begin
      nice_d  = (len_q != '0) && flags_q.repeat_found && flags_q.pair_found && !flags_q.overflow;
      len_d   = '0;
      flags_d = '0;
    end
  end

endmodule
